// File: rtl/life_pkg.sv
// Shared types and constants for the life generation scheduler.
package life_pkg;

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    WAIT  = 2'd1,
    GEN   = 2'd2
  } state_t;

  // Bit positions on the 5-bit edit-key bus
  localparam int FLIP  = 0;
  localparam int UP    = 1;
  localparam int DOWN  = 2;
  localparam int LEFT  = 3;
  localparam int RIGHT = 4;
  localparam int KEY_W = 5;

  // Run/step buttons sit above the edit keys on the button bus
  localparam int BTN_RUN  = 5;
  localparam int BTN_STEP = 6;
  localparam int BTN_W    = 7;

  localparam int DEF_X = 8;
  localparam int DEF_Y = 8;
  localparam int DEF_TIMEOUT = 2 * DEF_X * DEF_Y + 16;

  // A full pass touches every cell twice plus pipeline slack
  function automatic int timeout_for(input int x, input int y);
    return 2 * x * y + 16;
  endfunction

endpackage

// File: rtl/life_edge.sv
// Button history register with rising-edge detect, one bit per button.
module life_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] level_q;

  always_ff @(posedge clk) begin
    if (reset) level_q <= '0;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/life_seq.sv
// Generation scheduler and edit arbiter for the life board datapath.
// Optional macro LIFE_SEQ_SPEED_EN: up/down keys retune the run period outside PAUSE.
module life_seq
  import life_pkg::*;
#(
  parameter int X              = 8,
  parameter int Y              = 8,
  parameter int RATE_W         = 16,
  parameter int DEFAULT_PERIOD = 50000,
  parameter int GEN_W          = 8,
  parameter int TIMEOUT        = timeout_for(X, Y)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_flip,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             gen_done,
  output logic             key_nxt,
  output logic             key_flip,
  output logic             key_up,
  output logic             key_down,
  output logic             key_left,
  output logic             key_right,
  output logic             running,
  output logic             busy,
  output logic [GEN_W-1:0] gen_cnt,
  output logic             err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [RATE_W-1:0] PERIOD_INIT = RATE_W'(DEFAULT_PERIOD);

  logic [BTN_W-1:0] btn_level;
  logic [BTN_W-1:0] btn_rise;
  logic [KEY_W-1:0] edit_rise;
  logic             run_rise;
  logic             step_rise;

  state_t            state, state_n;
  logic              run_mode, run_mode_n;
  logic              pause_pending, pause_pending_n;
  logic [RATE_W-1:0] wcnt, wcnt_n;
  logic [TO_W-1:0]   tcnt, tcnt_n;
  logic [GEN_W-1:0]  gen_cnt_n;
  logic              err_n;
  logic [KEY_W-1:0]  keys, keys_n;
  logic [RATE_W-1:0] period;

  assign btn_level = {btn_step, btn_run, btn_right, btn_left, btn_down, btn_up, btn_flip};

  life_edge #(.W(BTN_W)) u_edge (
    .clk   (clk),
    .reset (reset),
    .level (btn_level),
    .rise  (btn_rise)
  );

  assign edit_rise = btn_rise[KEY_W-1:0];
  assign run_rise  = btn_rise[BTN_RUN];
  assign step_rise = btn_rise[BTN_STEP];

`ifdef LIFE_SEQ_SPEED_EN
  logic [RATE_W-1:0] period_n;

  function automatic logic [RATE_W-1:0] period_halve(input logic [RATE_W-1:0] p);
    return (p > RATE_W'(1)) ? (p >> 1) : RATE_W'(1);
  endfunction

  function automatic logic [RATE_W-1:0] period_double(input logic [RATE_W-1:0] p);
    return p[RATE_W-1] ? '1 : (p << 1);
  endfunction

  // Speed keys act only while the board is owned by the generation loop
  always_comb begin
    period_n = period;
    if (state == WAIT || (state == GEN && run_mode)) begin
      if (edit_rise[UP])        period_n = period_halve(period);
      else if (edit_rise[DOWN]) period_n = period_double(period);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) period <= PERIOD_INIT;
    else       period <= period_n;
  end
`else
  assign period = PERIOD_INIT;
`endif

  always_comb begin
    state_n         = state;
    run_mode_n      = run_mode;
    pause_pending_n = pause_pending;
    wcnt_n          = wcnt;
    tcnt_n          = tcnt;
    gen_cnt_n       = gen_cnt;
    err_n           = err;
    keys_n          = '0;
    case (state)
      PAUSE: begin
        keys_n = edit_rise;
        if (run_rise) begin
          state_n = WAIT;
          wcnt_n  = period - RATE_W'(1);
        end else if (step_rise) begin
          state_n    = GEN;
          run_mode_n = 1'b0;
          tcnt_n     = '0;
        end
      end
      WAIT: begin
        if (run_rise) begin
          state_n = PAUSE;
        end else if (wcnt == '0) begin
          state_n    = GEN;
          run_mode_n = 1'b1;
          tcnt_n     = '0;
        end else begin
          wcnt_n = wcnt - RATE_W'(1);
        end
      end
      GEN: begin
        tcnt_n = tcnt + 1'b1;
        if (gen_done) begin
          gen_cnt_n = gen_cnt + 1'b1;
          err_n     = 1'b0;
          // A run edge coinciding with completion counts as a pause request
          if (run_mode && !pause_pending && !run_rise) begin
            state_n = WAIT;
            wcnt_n  = period - RATE_W'(1);
          end else begin
            state_n         = PAUSE;
            pause_pending_n = 1'b0;
          end
        end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
          err_n           = 1'b1;
          state_n         = PAUSE;
          pause_pending_n = 1'b0;
        end else if (run_rise && run_mode) begin
          pause_pending_n = 1'b1;
        end
      end
      default: state_n = PAUSE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= PAUSE;
      run_mode      <= 1'b0;
      pause_pending <= 1'b0;
      wcnt          <= '0;
      tcnt          <= '0;
      gen_cnt       <= '0;
      err           <= 1'b0;
      keys          <= '0;
    end else begin
      state         <= state_n;
      run_mode      <= run_mode_n;
      pause_pending <= pause_pending_n;
      wcnt          <= wcnt_n;
      tcnt          <= tcnt_n;
      gen_cnt       <= gen_cnt_n;
      err           <= err_n;
      keys          <= keys_n;
    end
  end

  assign busy      = (state == GEN);
  assign key_nxt   = busy && (tcnt == '0);
  assign running   = (state == WAIT) || (busy && run_mode);
  assign key_flip  = keys[FLIP];
  assign key_up    = keys[UP];
  assign key_down  = keys[DOWN];
  assign key_left  = keys[LEFT];
  assign key_right = keys[RIGHT];

endmodule

// File: tb/tb_life_seq.sv
// Directed bench for life_seq with key-pulse and generation-count scoreboards.
module tb_life_seq;
  import life_pkg::*;

  localparam int RATE_W = 16;
  localparam int PERIOD = 10;
  localparam int GEN_W  = 2;
  localparam int TMO    = 40;

  typedef struct {
    logic [4:0] keys;
    int         at;
  } key_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_run = 1'b0, btn_step = 1'b0, btn_flip = 1'b0, btn_up = 1'b0;
  logic btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic gen_done;
  logic key_nxt, key_flip, key_up, key_down, key_left, key_right;
  logic running, busy, err;
  logic [GEN_W-1:0] gen_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_nxt    = 0;
  int n_busy   = 0;
  int last_nxt = 0;
  int nxt_gap  = 0;
  int dp_lat   = 20;
  bit gen_track = 1'b1;
  logic [GEN_W-1:0] gen_prev = '0;

  key_exp_t          key_q[$];
  logic [GEN_W-1:0]  gen_q[$];

  always #5 clk = ~clk;

  life_seq #(
    .X(8), .Y(8), .RATE_W(RATE_W), .DEFAULT_PERIOD(PERIOD),
    .GEN_W(GEN_W), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_run(btn_run), .btn_step(btn_step), .btn_flip(btn_flip),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .gen_done(gen_done),
    .key_nxt(key_nxt), .key_flip(key_flip), .key_up(key_up), .key_down(key_down),
    .key_left(key_left), .key_right(key_right),
    .running(running), .busy(busy), .gen_cnt(gen_cnt), .err(err)
  );

  // Datapath stand-in: answers each key_nxt with gen_done dp_lat clocks later
  initial begin
    gen_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      gen_done = 1'b0;
      if (key_nxt && dp_lat >= 0) begin
        repeat (dp_lat) begin @(posedge clk); #1; end
        gen_done = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [4:0] keys;
    key_exp_t   e;
    @(posedge clk); #1;
    cyc++;
    if (key_nxt) begin
      n_nxt++;
      nxt_gap  = cyc - last_nxt;
      last_nxt = cyc;
    end
    if (busy) n_busy++;
    keys = {key_right, key_left, key_down, key_up, key_flip};
    if (keys != 5'd0) begin
      if (key_q.size() == 0) begin
        check("key_spurious", 32'(keys), 32'd0);
      end else begin
        e = key_q.pop_front();
        check("key_pulse", 32'(keys), 32'(e.keys));
        check("key_cycle", cyc, e.at);
      end
    end
    if (gen_track && gen_cnt != gen_prev) begin
      if (gen_q.size() == 0) check("gen_cnt_spurious", 32'(gen_cnt), 32'(gen_prev));
      else                   check("gen_cnt_seq", 32'(gen_cnt), 32'(gen_q.pop_front()));
    end
    gen_prev = gen_cnt;
  endtask

  task automatic set_edit(input logic [4:0] k);
    btn_flip  = k[FLIP];
    btn_up    = k[UP];
    btn_down  = k[DOWN];
    btn_left  = k[LEFT];
    btn_right = k[RIGHT];
  endtask

  task automatic edit_pause(input logic [4:0] k);
    key_exp_t e;
    e.keys = k;
    e.at   = cyc + 1;
    key_q.push_back(e);
    set_edit(k);
    tick();
    set_edit(5'd0);
    tick();
    check("key_q_drained", key_q.size(), 0);
  endtask

  task automatic pulse_run();
    btn_run = 1'b1;
    tick();
    btn_run = 1'b0;
  endtask

  task automatic wait_nxt(input string tag);
    int k = 0;
    while (!key_nxt && k < 60) begin
      tick();
      k++;
    end
    check(tag, 32'(key_nxt), 32'd1);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_key_nxt", 32'(key_nxt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_running", 32'(running), 0);
    check("rst_gen_cnt", 32'(gen_cnt), 0);
    check("rst_err", 32'(err), 0);
    check("rst_keys", 32'({key_right, key_left, key_down, key_up, key_flip}), 0);
    reset = 1'b0;
    tick();

    // Single step, gen_done 20 clocks after key_nxt
    dp_lat = 20;
    n_nxt = 0; n_busy = 0;
    gen_q.push_back(2'd1);
    btn_step = 1'b1;
    tick();
    btn_step = 1'b0;
    check("step_key_nxt", 32'(key_nxt), 1);
    check("step_busy", 32'(busy), 1);
    check("step_running", 32'(running), 0);
    repeat (40) tick();
    check("step_nxt_count", n_nxt, 1);
    check("step_busy_cycles", n_busy, 21);
    check("step_gen_cnt", 32'(gen_cnt), 1);
    check("step_err", 32'(err), 0);
    check("step_idle", 32'(busy), 0);

    // Free run, period 10, gen_done 5 clocks after key_nxt; gen_cnt wraps at 4
    dp_lat = 5;
    n_nxt = 0;
    gen_q.push_back(2'd2);
    gen_q.push_back(2'd3);
    gen_q.push_back(2'd0);
    pulse_run();
    check("run_running", 32'(running), 1);
    repeat (49) tick();
    check("run_nxt_count", n_nxt, 3);
    check("run_nxt_gap", nxt_gap, 16);
    check("run_gen_cnt_wrap", 32'(gen_cnt), 0);
    check("run_running_wait", 32'(running), 1);

    // Run edge mid-GEN: generation completes, then pause
    gen_q.push_back(2'd1);
    wait_nxt("run_next_nxt");
    check("gen_running", 32'(running), 1);
    tick();
    n_nxt = 0;
    pulse_run();
    repeat (30) tick();
    check("pend_no_nxt", n_nxt, 0);
    check("pend_gen_cnt", 32'(gen_cnt), 1);
    check("pend_busy", 32'(busy), 0);
    check("pend_running", 32'(running), 0);
    edit_pause(5'b00001);

    // Edits dropped in WAIT and GEN, forwarded together in PAUSE
    gen_q.push_back(2'd2);
    pulse_run();
    tick();
    set_edit(5'b01001);
    tick();
    set_edit(5'd0);
    tick();
    wait_nxt("edit_gen_nxt");
    set_edit(5'b01001);
    tick();
    set_edit(5'd0);
    btn_run = 1'b1;
    tick();
    btn_run = 1'b0;
    repeat (20) tick();
    check("edit_gen_cnt", 32'(gen_cnt), 2);
    check("edit_paused", 32'(running), 0);
    edit_pause(5'b01001);

    // Timeout: no gen_done returned
    dp_lat = -1;
    btn_step = 1'b1;
    tick();
    btn_step = 1'b0;
    repeat (38) tick();
    check("tmo_busy_before", 32'(busy), 1);
    check("tmo_err_before", 32'(err), 0);
    tick(); tick();
    check("tmo_err", 32'(err), 1);
    check("tmo_busy", 32'(busy), 0);
    check("tmo_gen_cnt", 32'(gen_cnt), 2);
    dp_lat = 3;
    gen_q.push_back(2'd3);
    btn_step = 1'b1;
    tick();
    btn_step = 1'b0;
    repeat (10) tick();
    check("tmo_err_clear", 32'(err), 0);
    check("tmo_gen_cnt_next", 32'(gen_cnt), 3);

    // Run and step together: run wins; step in WAIT ignored; run edge in WAIT pauses
    n_nxt = 0;
    btn_run = 1'b1; btn_step = 1'b1;
    tick();
    btn_run = 1'b0; btn_step = 1'b0;
    check("both_running", 32'(running), 1);
    check("both_busy", 32'(busy), 0);
    btn_step = 1'b1;
    tick();
    btn_step = 1'b0;
    tick();
    check("wait_step_busy", 32'(busy), 0);
    pulse_run();
    check("wait_pause_running", 32'(running), 0);
    repeat (20) tick();
    check("wait_pause_nxt", n_nxt, 0);

    // Reset mid-GEN; the late gen_done must be ignored
    dp_lat = 10;
    btn_step = 1'b1;
    tick();
    btn_step = 1'b0;
    tick(); tick();
    check("mid_busy", 32'(busy), 1);
    gen_track = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_gen_cnt", 32'(gen_cnt), 0);
    tick();
    gen_track = 1'b1;
    repeat (15) tick();
    check("mid_late_done", 32'(gen_cnt), 0);
    check("mid_late_busy", 32'(busy), 0);

`ifdef LIFE_SEQ_SPEED_EN
    // Period halving floors at 1, doubling saturates at 2**RATE_W-1
    gen_track = 1'b0;
    dp_lat = 5;
    check("spd_default", 32'(dut.period), PERIOD);
    pulse_run();
    repeat (5) begin
      btn_up = 1'b1; tick();
      btn_up = 1'b0; tick();
    end
    check("spd_floor", 32'(dut.period), 1);
    repeat (17) begin
      btn_down = 1'b1; tick();
      btn_down = 1'b0; tick();
    end
    check("spd_ceiling", 32'(dut.period), 32'((1 << RATE_W) - 1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("spd_reset", 32'(dut.period), PERIOD);
`endif

    check("key_q_empty", key_q.size(), 0);
    check("gen_q_empty", gen_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/life_seq.md
Name: life_seq

Overview:
- Generation scheduler and edit arbiter for the life board datapath (data/cnt/pipe chain).
- Decides when the datapath starts a generation: single-step or free-run at a programmable period.
- Owns the board between user edits and generation passes; flip/cursor keys are forwarded only while paused.
- Sits between the key debouncers and the top-level key_nxt/key_flip/key_* inputs of the life core.

Parameters:
- X, 8, board width in cells
- Y, 8, board height in cells
- RATE_W, 16, width of free-run period counter
- DEFAULT_PERIOD, 50000, clocks between generations in run mode (must be >= 1 and < 2**RATE_W)
- GEN_W, 8, width of generation counter
- TIMEOUT, 2*X*Y+16, max clocks in GEN waiting for gen_done

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_run  in  1  debounced level; rising edge toggles run/pause
- btn_step  in  1  debounced level; rising edge requests one generation
- btn_flip, btn_up, btn_down, btn_left, btn_right  in  1 each  debounced edit levels
- gen_done  in  1  one-cycle pulse from datapath: generation pass complete
- key_nxt  out  1  one-cycle pulse: start generation
- key_flip, key_up, key_down, key_left, key_right  out  1 each  gated one-cycle edit pulses
- running  out  1  high in run mode (WAIT or GEN entered from WAIT)
- busy  out  1  high while in GEN
- gen_cnt  out  GEN_W  completed generations, wraps modulo 2**GEN_W
- err  out  1  sticky: a generation timed out

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state=PAUSE; all outputs 0; period=DEFAULT_PERIOD; button history registers 0; pause_pending=0.
- Edge detect: each btn_* is registered once. An edge is btn & ~btn_q. Edit outputs and state actions lag the button edge by 1 clock.
- States:
  - PAUSE: edit edges are forwarded as one-cycle pulses on key_flip/key_up/key_down/key_left/key_right.
    - run edge: -> WAIT, period counter := period-1.
    - step edge (no run edge in the same cycle): -> GEN with step mode.
    - run and step edges together: run wins, step is dropped.
  - WAIT: period counter decrements each clock.
    - Counter reaching 0: -> GEN with run mode.
    - run edge: -> PAUSE immediately, no generation.
    - step edges are ignored.
  - GEN: key_nxt pulses for exactly the first cycle of GEN. busy=1. A timeout counter counts from 0.
    - gen_done: gen_cnt+1 and err:=0.
      - Then -> WAIT (counter reloaded) if run mode and pause_pending=0.
      - Otherwise -> PAUSE and pause_pending:=0.
    - run edge during GEN sets pause_pending (run mode) or is ignored (step mode). The generation is never aborted.
    - run edge in the same cycle as gen_done: treated as pause_pending=1.
    - Timeout counter reaching TIMEOUT-1 with no gen_done: err:=1, -> PAUSE, gen_cnt unchanged, pause_pending:=0.
- Edit gating:
  - In WAIT and GEN, edit edges are dropped, never queued.
  - While in PAUSE, several edit edges in the same cycle are all forwarded in the same cycle.
- gen_done outside GEN: ignored.
- key_nxt can never assert twice without an intervening gen_done or timeout.
- running: 1 in WAIT, and in GEN entered from WAIT; otherwise 0.
- Reset mid-GEN: returns to PAUSE next cycle. A later gen_done is ignored.

Optional Feature:
- Macro: LIFE_SEQ_SPEED_EN.
- Defined:
  - In WAIT and GEN(run), btn_up/btn_down edges halve/double period.
  - Limits: period floor 1, ceiling 2**RATE_W-1; saturates, no wrap.
  - The new period applies at the next counter reload.
  - Edit outputs stay gated as above.
  - Reset restores DEFAULT_PERIOD.
- Not defined: period is constant DEFAULT_PERIOD; up/down edges outside PAUSE are simply dropped.

Decomposition:
- Shared package life_pkg:
  - state enum {PAUSE, WAIT, GEN}.
  - localparam for the default timeout expression.
  - Edit-key index constants FLIP/UP/DOWN/LEFT/RIGHT for the 5-bit key bus.
- One natural sub-module: life_edge (register plus rising-edge detect, parameterised width). Instantiate it once for the 7 buttons.

Test Plan:
- Reset, then btn_step rising with gen_done returned 20 clocks after key_nxt -> one key_nxt pulse, busy high for 21 cycles, gen_cnt=1, state PAUSE, err=0.
- DEFAULT_PERIOD=10, run edge, datapath returns gen_done 5 clocks after each key_nxt -> key_nxt pulses every 16 clocks (10 WAIT + 6 GEN); gen_cnt increments each time; running=1.
- Run edge issued mid-GEN -> current generation completes (gen_cnt+1), then PAUSE, no further key_nxt; btn_flip then yields a key_flip pulse.
- btn_left/btn_flip edges during WAIT and GEN -> no output pulses; the same edges in PAUSE -> one-cycle pulses, 1 clock after the edge.
- Step with gen_done never returned -> err=1 after TIMEOUT cycles, PAUSE, gen_cnt unchanged; next successful step clears err.
- With LIFE_SEQ_SPEED_EN, GEN_W=2: 4 completed generations -> gen_cnt wraps to 0. With period=1, three btn_up edges -> period stays 1 (saturation).
